// File: rtl/sum_1to10_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sum_1to10_pkg
// Purpose  : Shared types and constants for the sum-of-1-to-10 dedicated
//            processor. These are used by the controller and by the datapath.
//   ctrl_state_t : the eight controller states
//   ctrl_word_t  : the six datapath control bits, so one assignment decodes
//                  each state
//   SUM_LIMIT    : loop bound that the datapath comparator uses (10 < i)
// Revision : 1.0 - initial release
// ============================================================================
package sum_1to10_pkg;

    localparam logic [7:0] SUM_LIMIT = 8'd10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        CMP  = 3'd2,
        SUM  = 3'd3,
        INC  = 3'd4,
        OUT  = 3'd5,
        DONE = 3'd6,
        ERR  = 3'd7
    } ctrl_state_t;

    // The field order is also the bit order, from MSB to LSB.
    typedef struct packed {
        logic sum_src_sel;    // 0: zero, 1: adder
        logic i_src_sel;      // 0: zero, 1: adder
        logic sum_load;
        logic i_load;
        logic adder_src_sel;  // 0: sum,  1: constant 1
        logic out_load;
    } ctrl_word_t;

    localparam ctrl_word_t c_word_none = 6'b000000;
    localparam ctrl_word_t c_word_init = 6'b001100;  // sum <= 0, i <= 0
    localparam ctrl_word_t c_word_sum  = 6'b101000;  // sum <= sum + i
    localparam ctrl_word_t c_word_inc  = 6'b010110;  // i   <= 1 + i
    localparam ctrl_word_t c_word_out  = 6'b000001;  // out <= sum

endpackage
`default_nettype wire

// File: rtl/sum_1to10_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sum_1to10_ctrl
// Purpose  : Moore-FSM controller for the sum-of-1-to-10 datapath. It
//            sequences register initialisation, the accumulate/increment
//            loop and the result load. It also provides a start/busy/done
//            handshake and an iteration watchdog that ends in a sticky ERR
//            state.
// Ports    : clk, rst (synchronous, active-high)
//            start      - run request, sampled in IDLE/DONE/ERR only
//            not_iLe10  - datapath flag, high when 10 < i
//            sumSrcSel, iSrcSel, sumLoad, iLoad, adderSrcSel, OutLoad
//                       - datapath controls, decoded purely from state
//            busy, done, err - status outputs
//            iter_cnt   - number of SUM states in the current run
// Revision : 1.0 - initial release
// ============================================================================
module sum_1to10_ctrl
    import sum_1to10_pkg::*;
#(
    parameter int MAX_ITER = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       not_iLe10,
    output logic       sumSrcSel,
    output logic       iSrcSel,
    output logic       sumLoad,
    output logic       iLoad,
    output logic       adderSrcSel,
    output logic       OutLoad,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] iter_cnt
);

    localparam logic [3:0] c_max_iter = 4'(MAX_ITER);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic [3:0]  r_iter_cnt;
    ctrl_word_t  w_word;
    logic        w_busy;
    logic        w_done;
    logic        w_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_iter_cnt <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_iter_cnt <= 4'd0;
            end else if ((r_state == SUM) && (r_iter_cnt != 4'hF)) begin
                r_iter_cnt <= r_iter_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        w_word      = c_word_none;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = start ? INIT : IDLE;
            end
            INIT: begin
                w_word      = c_word_init;
                w_busy      = 1'b1;
                w_state_nxt = CMP;
            end
            CMP: begin
                w_busy = 1'b1;
                // The exit condition has priority over the watchdog. A run
                // that finishes exactly at the limit still completes.
                if (not_iLe10) begin
                    w_state_nxt = OUT;
                end else if (r_iter_cnt == c_max_iter) begin
                    w_state_nxt = ERR;
                end else begin
                    w_state_nxt = SUM;
                end
            end
            SUM: begin
                w_word      = c_word_sum;
                w_busy      = 1'b1;
                w_state_nxt = INC;
            end
            INC: begin
                w_word      = c_word_inc;
                w_busy      = 1'b1;
                w_state_nxt = CMP;
            end
            OUT: begin
                w_word      = c_word_out;
                w_busy      = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = start ? INIT : IDLE;
            end
            ERR: begin
                w_err       = 1'b1;
                w_state_nxt = start ? INIT : ERR;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign sumSrcSel   = w_word.sum_src_sel;
    assign iSrcSel     = w_word.i_src_sel;
    assign sumLoad     = w_word.sum_load;
    assign iLoad       = w_word.i_load;
    assign adderSrcSel = w_word.adder_src_sel;
    assign OutLoad     = w_word.out_load;
    assign busy        = w_busy;
    assign done        = w_done;
    assign err         = w_err;
    assign iter_cnt    = r_iter_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sum_1to10_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sum_1to10_ctrl
// Purpose  : Bench for sum_1to10_ctrl. It contains a behavioural model of the
//            datapath. Expected done/err events go into a queue, and a
//            negedge monitor compares them against the controller outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_1to10_ctrl;
    import sum_1to10_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       not_iLe10;
    logic       sumSrcSel, iSrcSel, sumLoad, iLoad, adderSrcSel, OutLoad;
    logic       busy, done, err;
    logic [3:0] iter_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit         is_err;
        int         at_cyc;
        logic [7:0] out_val;
        logic [3:0] iter;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sum_1to10_ctrl #(.MAX_ITER(12)) dut (
        .clk(clk), .rst(rst), .start(start), .not_iLe10(not_iLe10),
        .sumSrcSel(sumSrcSel), .iSrcSel(iSrcSel), .sumLoad(sumLoad),
        .iLoad(iLoad), .adderSrcSel(adderSrcSel), .OutLoad(OutLoad),
        .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
    );

    // Behavioural datapath model. The force_zero input pins the comparator
    // low so that the watchdog path can be exercised.
    logic [7:0] dp_sum, dp_i, dp_out, dp_adder;
    logic       force_zero;
    assign dp_adder  = (adderSrcSel ? 8'd1 : dp_sum) + dp_i;
    assign not_iLe10 = force_zero ? 1'b0 : (dp_i > SUM_LIMIT);
    always @(posedge clk) begin
        if (rst) begin
            dp_sum <= 8'd0;
            dp_i   <= 8'd0;
            dp_out <= 8'd0;
        end else begin
            if (sumLoad) dp_sum <= sumSrcSel ? dp_adder : 8'd0;
            if (iLoad)   dp_i   <= iSrcSel ? dp_adder : 8'd0;
            if (OutLoad) dp_out <= dp_sum;
        end
    end

    wire [5:0] word = {sumSrcSel, iSrcSel, sumLoad, iLoad, adderSrcSel, OutLoad};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_done(input int at, input logic [3:0] it);
        exp_t e;
        e.is_err = 1'b0; e.at_cyc = at; e.out_val = 8'd55; e.iter = it;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int at, input logic [3:0] it);
        exp_t e;
        e.is_err = 1'b1; e.at_cyc = at; e.out_val = 8'd0; e.iter = it;
        exp_q.push_back(e);
    endtask

    // Monitor: each done cycle or rising edge of err consumes one entry.
    logic err_q = 1'b0;
    always @(negedge clk) begin
        if (!rst && (done || (err && !err_q))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, err, done}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_kind_err", int'(err), int'(e.is_err));
                check("event_cycle", cyc, e.at_cyc);
                check("event_iter_cnt", int'(iter_cnt), int'(e.iter));
                check("event_busy", int'(busy), 0);
                if (!e.is_err) check("done_out", int'(dp_out), int'(e.out_val));
            end
        end
        err_q <= err;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s, s2;
        rst = 1'b1; start = 1'b0; force_zero = 1'b0;

        // Reset held for three cycles, then released with start low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_word", int'(word), 0);
        check("reset_iter", int'(iter_cnt), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_word", int'(word), 0);
        check("idle_status", int'({busy, done, err}), 0);
        check("idle_iter", int'(iter_cnt), 0);

        // Run 1: a single start pulse, plus a start pulse mid-run that must
        // have no effect.
        s = cyc; start = 1'b1; push_done(s + 37, 4'd11);
        @(negedge clk); start = 1'b0;
        check("init_word", int'(word), 6'b001100);
        check("init_busy", int'(busy), 1);
        wait_cyc(s + 2);  check("cmp_word", int'(word), 0);
        wait_cyc(s + 3);  check("sum_word", int'(word), 6'b101000);
        wait_cyc(s + 4);  check("inc_word", int'(word), 6'b010110);
        wait_cyc(s + 10); start = 1'b1;
        @(negedge clk);   start = 1'b0;
        wait_cyc(s + 35); check("cmp_exit_word", int'(word), 0);
        check("cmp_exit_busy", int'(busy), 1);
        wait_cyc(s + 36); check("out_word", int'(word), 6'b000001);
        wait_cyc(s + 37); check("done_word", int'(word), 0);
        check("done_high", int'(done), 1);
        wait_cyc(s + 38); check("after_done", int'({busy, done}), 0);

        // Run 2: start held high, so two runs execute back to back.
        wait_cyc(s + 40);
        s = cyc; start = 1'b1;
        push_done(s + 37, 4'd11); push_done(s + 74, 4'd11);
        wait_cyc(s + 38); check("b2b_init_word", int'(word), 6'b001100);
        wait_cyc(s + 74); start = 1'b0;
        wait_cyc(s + 75); check("b2b_idle", int'({busy, done}), 0);

        // Watchdog: comparator pinned low.
        wait_cyc(s + 78);
        s = cyc; force_zero = 1'b1; start = 1'b1; push_err(s + 39, 4'd12);
        @(negedge clk); start = 1'b0;
        wait_cyc(s + 38); check("wd_cmp_iter", int'(iter_cnt), 12);
        check("wd_cmp_err", int'(err), 0);
        wait_cyc(s + 42); check("err_sticky", int'(err), 1);
        check("err_word", int'(word), 0);
        check("err_iter", int'(iter_cnt), 12);
        force_zero = 1'b0;
        s2 = cyc; start = 1'b1; push_done(s2 + 37, 4'd11);
        @(negedge clk); start = 1'b0;
        check("err_clear", int'(err), 0);
        check("err_restart_word", int'(word), 6'b001100);
        wait_cyc(s2 + 2); check("restart_iter_clr", int'(iter_cnt), 0);

        // Reset in the middle of a run, followed by a fresh run.
        wait_cyc(s2 + 40);
        s = cyc; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cyc(s + 20); rst = 1'b1;
        wait_cyc(s + 21);
        check("midrst_word", int'(word), 0);
        check("midrst_status", int'({busy, done, err}), 0);
        check("midrst_iter", int'(iter_cnt), 0);
        rst = 1'b0;
        wait_cyc(s + 23);
        s = cyc; start = 1'b1; push_done(s + 37, 4'd11);
        @(negedge clk); start = 1'b0;
        wait_cyc(s + 42);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
